// File: rtl/stereo_window_builder_pkg.sv
// Shared types and helpers for stereo_window_builder (package stereo_pkg).
package stereo_pkg;

  localparam int PIXEL_BITS = 8;

  // Control states: FILL primes the line buffers, RUN emits windows,
  // HOLD marks a window waiting on the consumer.
  typedef enum logic [1:0] {
    FILL = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // A pixel closes a window once enough rows and columns lie behind it.
  function automatic logic is_eligible(input int unsigned row,
                                       input int unsigned col,
                                       input int unsigned first_row,
                                       input int unsigned first_col);
    return (row >= first_row) && (col >= first_col);
  endfunction

endpackage

// File: rtl/stereo_window_builder_line_buffer.sv
// stereo_line_buffer: ROWS stacked line stores, one column read and shifted
// up (towards row 0, the oldest) per write.
module stereo_line_buffer
  import stereo_pkg::*;
#(
  parameter int ROWS  = 4,
  parameter int WIDTH = 64,
  parameter int AW    = 6
) (
  input  logic                       clk,
  input  logic                       shift_en,
  input  logic [AW-1:0]              addr,
  input  logic [PIXEL_BITS-1:0]      pixel,
  output logic [ROWS*PIXEL_BITS-1:0] column
);

  logic [PIXEL_BITS-1:0] mem [ROWS][WIDTH];

  // Present the stored column at addr, oldest row in the lowest slot.
  always_comb begin
    column = '0;
    for (int r = 0; r < ROWS; r++) column[r*PIXEL_BITS +: PIXEL_BITS] = mem[r][addr];
  end

  // On a write, each row takes the newer row's pixel and the newest takes the input.
  always_ff @(posedge clk) begin
    if (shift_en) begin
      for (int r = 0; r < ROWS - 1; r++) mem[r][addr] <= mem[r+1][addr];
      mem[ROWS-1][addr] <= pixel;
    end
  end

endmodule

// File: rtl/stereo_window_builder.sv
// stereo_window_builder: turns a raster stream of left/right pixel pairs into
// left mask windows and right match windows for stereo_solver.
// Optional macro STEREO_WINDOW_STATS_EN adds the window_count output.
//
// Handshake: a pair transfers when in_valid && in_ready, a window when
// out_valid && out_ready; in_ready = !out_valid || out_ready, so a stalled
// window blocks input and outputs stay stable until taken.
module stereo_window_builder
  import stereo_pkg::*;
#(
  parameter int MASK_SIZE     = 5,
  parameter int MATCH_WIDE    = 18,
  parameter int POSITION_BITS = 8,
  parameter int IMG_WIDTH     = 64,
  parameter int IMG_HEIGHT    = 48
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic                                          in_sof,
  input  logic [PIXEL_BITS-1:0]                         in_left,
  input  logic [PIXEL_BITS-1:0]                         in_right,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [PIXEL_BITS*MASK_SIZE*MASK_SIZE-1:0]     flattern_mask,
  output logic [PIXEL_BITS*MASK_SIZE*MATCH_WIDE-1:0]    flattern_match_array,
  output logic [POSITION_BITS-1:0]                      mask_position,
  output logic [POSITION_BITS-1:0]                      match_position,
  output logic [POSITION_BITS-1:0]                      out_row,
  output logic                                          frame_done,
  output state_t                                        state_dbg
`ifdef STEREO_WINDOW_STATS_EN
  ,
  output logic [15:0]                                   window_count
`endif
);

  localparam int PB      = POSITION_BITS;
  localparam int LB_ROWS = MASK_SIZE - 1;
  localparam int AW      = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [PB-1:0] COL_MAX   = PB'(IMG_WIDTH - 1);
  localparam logic [PB-1:0] ROW_MAX   = PB'(IMG_HEIGHT - 1);
  localparam logic [PB-1:0] FILL_ROWS = PB'(MASK_SIZE - 1);
  localparam logic [PB-1:0] MASK_OFS  = PB'(MASK_SIZE - 1);
  localparam logic [PB-1:0] MATCH_OFS = PB'(MATCH_WIDE - 1);

  state_t state, state_next;
  logic [PB-1:0] col, row, eff_col, eff_row, nxt_col, nxt_row;
  logic accept, col_last, frame_last, eligible;
  logic [AW-1:0] lb_addr;
  logic [LB_ROWS*PIXEL_BITS-1:0] left_column, right_column;
  logic [PIXEL_BITS-1:0] lwin [MASK_SIZE][MASK_SIZE];
  logic [PIXEL_BITS-1:0] rwin [MASK_SIZE][MATCH_WIDE];

  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign lb_addr   = eff_col[AW-1:0];
  assign state_dbg = state;

  // Position of the pair on the input (in_sof forces 0,0) and where the counters go next.
  always_comb begin
    eff_col    = in_sof ? '0 : col;
    eff_row    = in_sof ? '0 : row;
    col_last   = (eff_col == COL_MAX);
    frame_last = col_last && (eff_row == ROW_MAX);
    nxt_col    = col_last ? '0 : eff_col + 1'b1;
    nxt_row    = eff_row;
    if (frame_last)    nxt_row = '0;
    else if (col_last) nxt_row = eff_row + 1'b1;
    eligible   = is_eligible(32'(eff_row), 32'(eff_col), MASK_SIZE - 1, MATCH_WIDE - 1);
  end

  // Raster position counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      col <= nxt_col;
      row <= nxt_row;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= state_next;
  end

  // Next state: frame wrap or in_sof always restarts in FILL.
  always_comb begin
    state_next = state;
    case (state)
      FILL: if (accept && nxt_row == FILL_ROWS) state_next = RUN;
      RUN:  if (out_valid && !out_ready) state_next = HOLD;
      HOLD: if (out_ready) state_next = RUN;
      default: state_next = FILL;
    endcase
    if (accept && (in_sof || frame_last)) state_next = FILL;
  end

  stereo_line_buffer #(.ROWS(LB_ROWS), .WIDTH(IMG_WIDTH), .AW(AW)) u_left_lb (
    .clk(clk), .shift_en(accept), .addr(lb_addr), .pixel(in_left), .column(left_column)
  );

  stereo_line_buffer #(.ROWS(LB_ROWS), .WIDTH(IMG_WIDTH), .AW(AW)) u_right_lb (
    .clk(clk), .shift_en(accept), .addr(lb_addr), .pixel(in_right), .column(right_column)
  );

  // Column shift windows; only the mask-wide tail of the left window is ever read.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < MASK_SIZE; r++) begin
        for (int c = 0; c < MASK_SIZE; c++)  lwin[r][c] <= '0;
        for (int c = 0; c < MATCH_WIDE; c++) rwin[r][c] <= '0;
      end
    end else if (accept) begin
      for (int r = 0; r < MASK_SIZE; r++) begin
        for (int c = 0; c < MASK_SIZE - 1; c++)  lwin[r][c] <= lwin[r][c+1];
        for (int c = 0; c < MATCH_WIDE - 1; c++) rwin[r][c] <= rwin[r][c+1];
      end
      for (int r = 0; r < LB_ROWS; r++) begin
        lwin[r][MASK_SIZE-1]  <= left_column[r*PIXEL_BITS +: PIXEL_BITS];
        rwin[r][MATCH_WIDE-1] <= right_column[r*PIXEL_BITS +: PIXEL_BITS];
      end
      lwin[MASK_SIZE-1][MASK_SIZE-1]  <= in_left;
      rwin[MASK_SIZE-1][MATCH_WIDE-1] <= in_right;
    end
  end

  // Flatten the windows row-major onto the output buses.
  always_comb begin
    flattern_mask        = '0;
    flattern_match_array = '0;
    for (int r = 0; r < MASK_SIZE; r++) begin
      for (int c = 0; c < MASK_SIZE; c++)
        flattern_mask[(r*MASK_SIZE+c)*PIXEL_BITS +: PIXEL_BITS] = lwin[r][c];
      for (int c = 0; c < MATCH_WIDE; c++)
        flattern_match_array[(r*MATCH_WIDE+c)*PIXEL_BITS +: PIXEL_BITS] = rwin[r][c];
    end
  end

  // Output valid, window coordinates and end-of-frame pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid      <= 1'b0;
      frame_done     <= 1'b0;
      mask_position  <= '0;
      match_position <= '0;
      out_row        <= '0;
    end else begin
      frame_done <= accept && frame_last;
      if (accept) begin
        out_valid <= eligible;
        if (eligible) begin
          mask_position  <= eff_col - MASK_OFS;
          match_position <= eff_col - MATCH_OFS;
          out_row        <= eff_row - FILL_ROWS;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef STEREO_WINDOW_STATS_EN
  logic [15:0] win_cnt, win_cnt_plus;
  logic        latch_pend;

  // Running count including a window taken this cycle, saturating.
  always_comb begin
    win_cnt_plus = win_cnt;
    if (out_valid && out_ready && win_cnt != 16'hFFFF) win_cnt_plus = win_cnt + 1'b1;
  end

  // Count taken windows; publish once the frame's last window has left.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt      <= '0;
      window_count <= '0;
      latch_pend   <= 1'b0;
    end else begin
      if (accept && eff_col == '0 && eff_row == '0) win_cnt <= '0;
      else                                          win_cnt <= win_cnt_plus;
      if (frame_done || latch_pend) begin
        if (!out_valid || out_ready) begin
          window_count <= win_cnt_plus;
          latch_pend   <= 1'b0;
        end else begin
          latch_pend   <= 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_stereo_window_builder.sv
// Self-checking bench for stereo_window_builder (20x6 image, 3x3 mask, 6-wide match).
module tb_stereo_window_builder;
  import stereo_pkg::*;

  localparam int W  = 20;
  localparam int H  = 6;
  localparam int MS = 3;
  localparam int MW = 6;
  localparam int MB = MS*MS*8;
  localparam int AB = MS*MW*8;
  localparam int EW = MB + AB + 24;
  localparam int EXP_WIN = (H - MS + 1) * (W - MW + 1);

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic in_valid, in_ready, in_sof, out_valid, out_ready, frame_done;
  logic [7:0] in_left, in_right, mask_position, match_position, out_row;
  logic [MB-1:0] flattern_mask;
  logic [AB-1:0] flattern_match_array;
  state_t state_dbg;
`ifdef STEREO_WINDOW_STATS_EN
  logic [15:0] window_count;
`endif

  stereo_window_builder #(
    .MASK_SIZE(MS), .MATCH_WIDE(MW), .POSITION_BITS(8), .IMG_WIDTH(W), .IMG_HEIGHT(H)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
    .in_left(in_left), .in_right(in_right), .out_valid(out_valid), .out_ready(out_ready),
    .flattern_mask(flattern_mask), .flattern_match_array(flattern_match_array),
    .mask_position(mask_position), .match_position(match_position), .out_row(out_row),
    .frame_done(frame_done), .state_dbg(state_dbg)
`ifdef STEREO_WINDOW_STATS_EN
    , .window_count(window_count)
`endif
  );

  int cmp_cnt = 0;
  int err_cnt = 0;
  int delivered = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference model: the whole frame as received, windows cut straight from it
  logic [7:0] img_l [H][W];
  logic [7:0] img_r [H][W];
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] head;
  logic [MB-1:0] t_mask;
  logic [AB-1:0] t_match;
  int m_row = 0, m_col = 0;
  logic exp_fd = 1'b0;

  // scoreboard: compare every valid cycle, pop on transfer, model every accepted pair
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_row = 0; m_col = 0; exp_fd = 1'b0;
    end else if (mon_en) begin
      chk("frame_done", frame_done, exp_fd);
      chk("in_ready_rule", in_ready, !out_valid || out_ready);
      chk("out_valid", out_valid, exp_q.size() != 0);
      if (out_valid && exp_q.size() != 0) begin
        head = exp_q[0];
        chk("mask", flattern_mask, head[EW-1 -: MB]);
        chk("match", flattern_match_array, head[EW-MB-1 -: AB]);
        chk("mask_position", mask_position, head[23:16]);
        chk("match_position", match_position, head[15:8]);
        chk("out_row", out_row, head[7:0]);
        if (out_ready) begin
          void'(exp_q.pop_front());
          delivered++;
        end
      end
      if (in_valid && in_ready) begin
        if (in_sof) begin m_row = 0; m_col = 0; end
        img_l[m_row][m_col] = in_left;
        img_r[m_row][m_col] = in_right;
        if (m_row >= MS-1 && m_col >= MW-1) begin
          for (int r = 0; r < MS; r++) begin
            for (int c = 0; c < MS; c++)
              t_mask[(r*MS+c)*8 +: 8] = img_l[m_row-MS+1+r][m_col-MS+1+c];
            for (int c = 0; c < MW; c++)
              t_match[(r*MW+c)*8 +: 8] = img_r[m_row-MS+1+r][m_col-MW+1+c];
          end
          exp_q.push_back({t_mask, t_match, 8'(m_col-MS+1), 8'(m_col-MW+1), 8'(m_row-MS+1)});
        end
        exp_fd = (m_row == H-1 && m_col == W-1);
        m_col++;
        if (m_col == W) begin
          m_col = 0; m_row++;
          if (m_row == H) m_row = 0;
        end
      end else begin
        exp_fd = 1'b0;
      end
    end
  end

  // driver: present one pair and hold it until accepted
  task automatic send(input int r, input int c, input bit sof, input bit rnd, input bit bp);
    int guard;
    logic [7:0] l;
    guard = 0;
    l = rnd ? 8'($urandom_range(0, 255)) : 8'((r*W + c) % 256);
    in_left = l; in_right = l + 8'd100; in_sof = sof; in_valid = 1'b1;
    if (bp) out_ready = ($urandom_range(0, 3) != 0);
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      if (bp) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      guard++;
    end
    chk("accept_timeout", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_frame_done"}, frame_done, 1'b0);
    chk({tag, "_mask_position"}, mask_position, 8'd0);
    chk({tag, "_match_position"}, match_position, 8'd0);
    chk({tag, "_out_row"}, out_row, 8'd0);
    chk({tag, "_mask"}, flattern_mask, '0);
    chk({tag, "_match"}, flattern_match_array, '0);
    chk({tag, "_in_ready"}, in_ready, 1'b1);
    chk({tag, "_state"}, state_dbg, FILL);
  endtask

  task automatic end_of_frame(input string tag);
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_windows"}, delivered, EXP_WIN);
`ifdef STEREO_WINDOW_STATS_EN
    chk({tag, "_window_count"}, window_count, 16'(EXP_WIN));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_left = '0; in_right = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0; mon_en = 1'b1;

    // frame 1: formula pixels, directed first-window and frame_done checks
    delivered = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        send(r, c, 1'b0, 1'b0, 1'b0);
        if (r < MS-1) chk("fill_no_output", out_valid, 1'b0);
        if (r == 2 && c == 5) begin
          chk("first_valid", out_valid, 1'b1);
          chk("first_mask_position", mask_position, 8'd3);
          chk("first_match_position", match_position, 8'd0);
          chk("first_out_row", out_row, 8'd0);
          chk("first_mask0", flattern_mask[7:0], 8'd3);
          chk("first_mask8", flattern_mask[71:64], 8'd45);
          chk("first_match0", flattern_match_array[7:0], 8'd100);
          chk("first_match17", flattern_match_array[143:136], 8'd145);
        end
        if (r == H-1 && c == W-1) chk("frame_done_pulse", frame_done, 1'b1);
      end
    end
    @(posedge clk); #1;
    chk("frame_done_single", frame_done, 1'b0);
    end_of_frame("frame1");

    // frame 2: random pixels, consumer stalls 4 cycles on the 3rd window
    delivered = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        send(r, c, 1'b0, 1'b1, 1'b0);
        if (r == 2 && c == 7) begin
          out_ready = 1'b0;
          for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, 1'b0);
            chk("stall_match_position", match_position, 8'd2);
          end
          @(posedge clk); #1;
          out_ready = 1'b1;
        end
      end
    end
    end_of_frame("stall_frame");

    // frame 3: random pixels, random backpressure
    delivered = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        send(r, c, 1'b0, 1'b1, 1'b1);
    end_of_frame("random_bp_frame");

    // frame 4: in_sof at row 3 col 7 restarts the frame
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < W; c++)
        if (r < 3 || c < 7) send(r, c, 1'b0, 1'b1, 1'b0);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        send(r, c, (r == 0 && c == 0), 1'b1, 1'b0);
        if (r == 0 && c == 0) delivered = 0;
        if (r < MS-1) chk("sof_fill_no_output", out_valid, 1'b0);
        if (r == 2 && c == 5) begin
          chk("sof_first_valid", out_valid, 1'b1);
          chk("sof_first_out_row", out_row, 8'd0);
          chk("sof_first_mask_position", mask_position, 8'd3);
        end
      end
    end
    end_of_frame("sof_frame");

    // frame 5: reset in the middle of row 4, then a frame without in_sof
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < W; c++)
        if (r < 4 || c < 10) send(r, c, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset("mid_reset");
    delivered = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        send(r, c, 1'b0, 1'b1, 1'b0);
        if (r < MS-1) chk("post_reset_no_output", out_valid, 1'b0);
        if (r == 2 && c == 5) begin
          chk("post_reset_first_valid", out_valid, 1'b1);
          chk("post_reset_out_row", out_row, 8'd0);
          chk("post_reset_match_position", match_position, 8'd0);
        end
      end
    end
    end_of_frame("post_reset_frame");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/stereo_window_builder.md
Name: stereo_window_builder

Overview:
- Upstream feeder for stereo_solver.
- Accepts a raster stream of left/right pixel pairs.
- Buffers MASK_SIZE-1 previous rows of each image.
- Emits one flattened left mask window plus one flattened right match window per eligible pixel, with the column positions stereo_solver consumes.
- Valid/ready handshake on both sides, so it can sit between the camera/DMA front end and the disparity solver.

Parameters:
- MASK_SIZE, 5, mask edge length in pixels (odd, ≥3).
- MATCH_WIDE, 18, match array width in columns (≥ MASK_SIZE).
- POSITION_BITS, 8, width of position/row/column counters.
- IMG_WIDTH, 64, pixels per row (≥ MATCH_WIDE, ≤ 2^POSITION_BITS).
- IMG_HEIGHT, 48, rows per frame (≥ MASK_SIZE, ≤ 2^POSITION_BITS).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  pixel pair present.
- in_ready  out  1  block accepts a pair this cycle.
- in_sof  in  1  qualified by in_valid: this pair is row 0, col 0.
- in_left  in  8  left image pixel.
- in_right  in  8  right image pixel.
- out_valid  out  1  window outputs valid.
- out_ready  in  1  consumer accepts the window.
- flattern_mask  out  8*MASK_SIZE*MASK_SIZE  left window; element r*MASK_SIZE+c at [i*8 +: 8].
- flattern_match_array  out  8*MASK_SIZE*MATCH_WIDE  right window; element r*MATCH_WIDE+c at [i*8 +: 8].
- mask_position  out  POSITION_BITS  image column of mask column 0.
- match_position  out  POSITION_BITS  image column of match column 0.
- out_row  out  POSITION_BITS  image row of window row 0.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted.

Behaviour:
- Transfers: input on in_valid && in_ready; output on out_valid && out_ready.
- in_ready = !out_valid || out_ready. A stalled output blocks input; no pixel is ever dropped.
- Counters col and row, reset 0:
  - col increments per accepted pair and wraps at IMG_WIDTH-1, then row increments.
  - At row IMG_HEIGHT-1, col IMG_WIDTH-1 both wrap to 0 and frame_done pulses the next cycle.
  - An accepted pair with in_sof=1 is treated as (0,0) regardless of the counters. Counters restart and buffer contents are considered stale (FILL re-entered).
- Storage: per image, MASK_SIZE-1 line buffers of IMG_WIDTH bytes plus a MASK_SIZE-row × MATCH_WIDE-column column shift window.
  - On each accepted pair, the current column (line buffer outputs plus the new pixel, oldest row = window row 0) shifts in at column MATCH_WIDE-1.
  - The left mask is the rightmost MASK_SIZE columns of the left window.
  - The right match array is the full right window.
- Eligibility: a window is emitted when the accepted pair has row ≥ MASK_SIZE-1 and col ≥ MATCH_WIDE-1.
  - Latency: out_valid rises 1 cycle after acceptance; outputs are registered and held stable while out_valid && !out_ready.
  - mask_position = col-MASK_SIZE+1; match_position = col-MATCH_WIDE+1; out_row = row-MASK_SIZE+1.
- FSM (state reset FILL):
  - FILL: row < MASK_SIZE-1; no output. Moves to RUN when the row counter reaches MASK_SIZE-1.
  - RUN: eligible pairs emit windows. Moves to HOLD when out_valid && !out_ready.
  - HOLD: in_ready=0; returns to RUN on out_ready.
  - Frame wrap or in_sof from any state moves to FILL. A window pending in HOLD is still delivered before the next pair is accepted.
- Reset values: out_valid=0, frame_done=0, positions/out_row=0, window buses=0, in_ready=1. Reset mid-frame discards all state; the next pair is (0,0).
- No arithmetic beyond the counters; positions never underflow because they are only loaded when eligible.

Optional Feature:
- Macro STEREO_WINDOW_STATS_EN.
- Defined: adds output window_count (16 bit), counting windows accepted by the consumer in the current frame. It saturates at 0xFFFF, is latched into window_count on frame_done, and clears its internal counter at frame start/in_sof.
- Undefined: the port and counter are absent.

Decomposition:
- Package stereo_pkg: PIXEL_BITS=8, FSM state enum (FILL, RUN, HOLD), and an eligibility helper function.
- One sub-module stereo_line_buffer (MASK_SIZE-1 rows × IMG_WIDTH, write/shift enable, outputs the column of older rows), instantiated once for left and once for right.

Test Plan:
Bench parameters IMG_WIDTH=20, IMG_HEIGHT=6, MASK_SIZE=3, MATCH_WIDE=6. Left pixel = row*20+col, right pixel = left+100 (mod 256). out_ready=1 unless stated.
- First window → out_valid one cycle after accepting (2,5); mask_position=3, match_position=0, out_row=0; mask[0]=3, mask[8]=45; match[0]=100, match[17]=145.
- Full frame → exactly (6-2)*(20-5)=60 windows, no output during rows 0–1; frame_done pulses once, one cycle after (5,19).
- out_ready held low 4 cycles at the 3rd window → in_ready=0 for those cycles, outputs stable; window delivered on release; subsequent windows show consecutive match_position with no gap or duplicate.
- in_sof asserted at row 3 col 7 → counters restart, next 2 rows produce no windows, first new window has out_row=0.
- rst asserted mid-row 4 → all outputs reset values next cycle; next pair is treated as (0,0).
- With STEREO_WINDOW_STATS_EN → window_count=60 after frame_done; with out_ready stalls it is still 60.
